// File: rtl/sa_operand_sequencer_if.sv
// Operand, adder and result signals of sa_operand_sequencer in one bundle.
// Both streams use valid/ready: a transfer happens on a posedge where valid and ready
// are both high; the sender holds its data stable while valid is high and ready is low.
interface sa_operand_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic [WIDTH-1:0] sa_data_a;
  logic [WIDTH-1:0] sa_data_b;
  logic             sa_reset;
  logic [WIDTH-1:0] sa_out;
  logic             sa_cout;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;

  modport slave (
    input  in_valid, in_a, in_b, sa_out, sa_cout, res_ready,
    output in_ready, sa_data_a, sa_data_b, sa_reset, res_valid, res_sum, res_cout
  );

  modport master (
    output in_valid, in_a, in_b, sa_out, sa_cout, res_ready,
    input  in_ready, sa_data_a, sa_data_b, sa_reset, res_valid, res_sum, res_cout
  );
endinterface

// File: rtl/sa_operand_sequencer.sv
// Queues operand pairs, runs the serial_adder once per pair with a one-cycle reset pulse,
// and returns each captured sum/carry on a result stream.
module sa_operand_sequencer #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int SA_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  sa_operand_sequencer_if.slave bus,
  output logic [1:0]            dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SA_CYCLES + 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] RUN_LAST = CW'(SA_CYCLES);
  localparam logic [CW-1:0] RUN_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;
  logic             empty;

  assign empty        = (count == '0);
  assign bus.in_ready = (count != FULL);
  assign push         = bus.in_valid & bus.in_ready;
  // res_valid is always high in HOLD, so res_ready alone completes the result transfer.
  assign pop          = !empty && ((state == IDLE) || ((state == HOLD) && bus.res_ready));
  // The adder sits in reset with us, plus exactly the one LOAD cycle per launch.
  assign bus.sa_reset = reset | (state == LOAD);
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_a;
      mem_b[wr_ptr] <= bus.in_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.sa_data_a <= '0;
      bus.sa_data_b <= '0;
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
      bus.res_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            bus.sa_data_a <= mem_a[rd_ptr];
            bus.sa_data_b <= mem_b[rd_ptr];
            state         <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (cnt == RUN_LAST) begin
            bus.res_sum   <= bus.sa_out;
            bus.res_cout  <= bus.sa_cout;
            bus.res_valid <= 1'b1;
            state         <= HOLD;
          end else begin
            cnt <= cnt + RUN_ONE;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            if (pop) begin
              bus.sa_data_a <= mem_a[rd_ptr];
              bus.sa_data_b <= mem_b[rd_ptr];
              state         <= LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_operand_sequencer.sv
// Bench for sa_operand_sequencer: a bit-serial adder model drives the sa_* side, and a
// scoreboard predicts every result and launch from the accepted operand pairs.
module tb_sa_operand_sequencer;
  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  sa_operand_sequencer_if #(.WIDTH(W)) bus ();

  sa_operand_sequencer #(.WIDTH(W), .DEPTH(4), .SA_CYCLES(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- serial adder model (LSB first, one bit per enabled cycle) ----------------
  logic [W-1:0] sh_a, sh_b, acc;
  logic         carry;
  int           shifts;
  logic         s_bit, c_bit;
  assign s_bit = sh_a[0] ^ sh_b[0] ^ carry;
  assign c_bit = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));
  always @(posedge clk) begin
    if (bus.sa_reset) begin
      sh_a <= bus.sa_data_a; sh_b <= bus.sa_data_b;
      acc <= '0; carry <= 1'b0; shifts <= 0;
    end else if (shifts < W) begin
      acc <= {s_bit, acc[W-1:1]}; carry <= c_bit;
      sh_a <= sh_a >> 1; sh_b <= sh_b >> 1; shifts <= shifts + 1;
    end
  end
  assign bus.sa_out  = acc;
  assign bus.sa_cout = carry;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int results_seen = 0;
  logic [W:0]     exp_q[$];
  logic [2*W-1:0] launch_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic         prev_hold = 1'b0;
  logic [W:0]   prev_res;
  logic         prev_sa_reset = 1'b0;
  logic         tracking = 1'b0;
  logic [2*W-1:0] snap;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      launch_q.delete();
      prev_hold = 1'b0; prev_sa_reset = 1'b0; tracking = 1'b0;
      check("sa_reset_in_reset", 32'(bus.sa_reset), 32'd1);
    end else begin
      if (prev_hold)
        check("res_hold", 32'({bus.res_valid, bus.res_cout, bus.res_sum}), 32'({1'b1, prev_res}));
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
        else check("result", 32'({bus.res_cout, bus.res_sum}), 32'(exp_q.pop_front()));
        results_seen++;
      end
      prev_hold = bus.res_valid && !bus.res_ready;
      prev_res  = {bus.res_cout, bus.res_sum};
      if (tracking) begin
        check("sa_data_stable", 32'({bus.sa_data_a, bus.sa_data_b}), 32'(snap));
        if (bus.res_valid) tracking = 1'b0;
      end
      if (bus.sa_reset) begin
        check("sa_reset_width", 32'(prev_sa_reset), 32'd0);
        if (launch_q.size() == 0) check("unexpected_launch", 32'd1, 32'd0);
        else check("launch_operands", 32'({bus.sa_data_a, bus.sa_data_b}), 32'(launch_q.pop_front()));
        snap = {bus.sa_data_a, bus.sa_data_b};
        tracking = 1'b1;
      end
      prev_sa_reset = bus.sa_reset;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back((W + 1)'(bus.in_a) + (W + 1)'(bus.in_b));
        launch_q.push_back({bus.in_a, bus.in_b});
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic toggle_en = 1'b0;
  always @(posedge clk) if (toggle_en) begin #1; bus.res_ready = 1'($urandom_range(0, 1)); end

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin @(posedge clk); #1; break; end
      guard++;
      if (guard > 200) begin check("push_timeout", 32'd0, 32'd1); break; end
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.res_valid && n < 100);
    if (!bus.res_valid) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || bus.res_valid) && guard < 1000) begin @(posedge clk); guard++; end
    #1;
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int n, base;
  initial begin
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_res", 32'({bus.res_valid, bus.res_cout, bus.res_sum}), 32'd0);
    check("rst_sa_data", 32'({bus.sa_data_a, bus.sa_data_b}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 1: single pair, latency and value
    bus.res_ready = 1'b1;
    push_pair(4'h3, 4'h5); bus.in_valid = 1'b0;
    wait_valid(n);
    check("t1_latency_edges", 32'(n - 1), 32'd8);
    check("t1_result", 32'({bus.res_cout, bus.res_sum}), 32'h08);
    wait_drain();

    // 2: back-to-back pairs, ordering and spacing
    push_pair(4'h9, 4'h8); push_pair(4'hF, 4'h1); bus.in_valid = 1'b0;
    wait_valid(n);
    check("t2_first", 32'({bus.res_cout, bus.res_sum}), 32'h11);
    wait_valid(n);
    check("t2_spacing", 32'(n), 32'd8);
    check("t2_second", 32'({bus.res_cout, bus.res_sum}), 32'h10);
    wait_drain();

    // 3: back-pressure fills the FIFO, then drain in order
    bus.res_ready = 1'b0;
    base = results_seen;
    push_pair(4'h1, 4'h2); push_pair(4'h3, 4'h4); push_pair(4'h5, 4'h6);
    push_pair(4'hA, 4'hB); push_pair(4'hF, 4'hF); bus.in_valid = 1'b0;
    @(negedge clk);
    check("t3_full_in_ready", 32'(bus.in_ready), 32'd0);
    wait_valid(n);
    check("t3_first_held", 32'({bus.res_cout, bus.res_sum}), 32'h03);
    repeat (6) @(posedge clk); #1;
    bus.res_ready = 1'b1;
    wait_drain();
    check("t3_count", 32'(results_seen - base), 32'd5);

    // 5: reset during RUN discards the pair
    push_pair(4'h7, 4'h7); bus.in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t5_in_ready", 32'(bus.in_ready), 32'd1);
    check("t5_res_valid", 32'(bus.res_valid), 32'd0);
    check("t5_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk); #1; reset = 1'b0;
    base = results_seen;
    repeat (15) @(posedge clk); #1;
    check("t5_no_result", 32'(results_seen - base), 32'd0);
    push_pair(4'h2, 4'h2); bus.in_valid = 1'b0;
    wait_valid(n);
    check("t5_after_reset", 32'({bus.res_cout, bus.res_sum}), 32'h04);
    wait_drain();

    // 6: in_valid held across the full boundary, res_ready random
    base = results_seen;
    toggle_en = 1'b1;
    for (int i = 0; i < 20; i++)
      push_pair(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    bus.in_valid = 1'b0;
    wait_drain();
    toggle_en = 1'b0;
    @(posedge clk); #1; bus.res_ready = 1'b1;
    check("t6_count", 32'(results_seen - base), 32'd20);
    check("launch_q_empty", 32'(launch_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
